// File: rtl/dds_sweep_ctrl.sv
// -----------------------------------------------------------------------------
// dds_sweep_ctrl
//
// Frequency-sweep sequencer for the DDS phase-increment input. After a go
// strobe, phase_inc is loaded with the start value and then stepped toward the
// stop value (inclusive). Each value is held for a programmable number of codec
// sample frames, counted as frame_tick pulses, so every update is frame-aligned.
//
// Ports:
//   clk            system clock (60 MHz domain)
//   rst            asynchronous, active-high reset
//   frame_tick     one-cycle pulse per codec sample frame
//   cfg_start_inc  first phase increment of the sweep
//   cfg_stop_inc   upper bound of the sweep (inclusive)
//   cfg_step       increment added per step
//   cfg_dwell      frames held per value (0 is treated as 1)
//   cfg_loop       0 = single sweep, 1 = restart at start after the last value
//   go             one-cycle start strobe (ignored while sweeping)
//   abort          one-cycle stop strobe (wins over go and over an advance)
//   phase_inc      phase increment driven to the DDS
//   busy           high while sweeping
//   done           one-cycle pulse at the natural end of a single sweep
//   step_strobe    one-cycle pulse whenever phase_inc is loaded or advanced
// -----------------------------------------------------------------------------
module dds_sweep_ctrl #(
    parameter int unsigned     PW      = 32,
    parameter int unsigned     DW      = 16,
    parameter logic [PW-1:0]   RST_INC = PW'(100000)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          frame_tick,
    input  logic [PW-1:0] cfg_start_inc,
    input  logic [PW-1:0] cfg_stop_inc,
    input  logic [PW-1:0] cfg_step,
    input  logic [DW-1:0] cfg_dwell,
    input  logic          cfg_loop,
    input  logic          go,
    input  logic          abort,
    output logic [PW-1:0] phase_inc,
    output logic          busy,
    output logic          done,
    output logic          step_strobe
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t        state;

    // Shadow copies of the configuration, captured on go.
    logic [PW-1:0] start_r;
    logic [PW-1:0] stop_r;
    logic [PW-1:0] step_r;
    logic [DW-1:0] dwell_r;     // already clamped to at least 1
    logic          loop_r;

    logic [DW-1:0] dwell_cnt;

    logic [DW-1:0] dwell_eff;
    logic [PW:0]   next_sum;
    logic          adv_ok;

    always_comb begin
        dwell_eff = (cfg_dwell == '0) ? DW'(1) : cfg_dwell;
    end

    // One extra bit catches the carry so the sweep ends instead of wrapping.
    always_comb begin
        next_sum = {1'b0, phase_inc} + {1'b0, step_r};
        adv_ok   = !next_sum[PW] && (next_sum[PW-1:0] <= stop_r);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            phase_inc   <= RST_INC;
            busy        <= 1'b0;
            done        <= 1'b0;
            step_strobe <= 1'b0;
            start_r     <= '0;
            stop_r      <= '0;
            step_r      <= '0;
            dwell_r     <= '0;
            loop_r      <= 1'b0;
            dwell_cnt   <= '0;
        end else begin
            done        <= 1'b0;
            step_strobe <= 1'b0;

            case (state)
                IDLE: begin
                    if (go && !abort) begin
                        start_r     <= cfg_start_inc;
                        stop_r      <= cfg_stop_inc;
                        step_r      <= cfg_step;
                        dwell_r     <= dwell_eff;
                        loop_r      <= cfg_loop;
                        dwell_cnt   <= dwell_eff;
                        phase_inc   <= cfg_start_inc;
                        busy        <= 1'b1;
                        step_strobe <= 1'b1;
                        state       <= RUN;
                    end
                end

                RUN: begin
                    if (abort) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else if (frame_tick) begin
                        if (dwell_cnt <= DW'(1)) begin
                            dwell_cnt <= dwell_r;
                            if (adv_ok) begin
                                phase_inc   <= next_sum[PW-1:0];
                                step_strobe <= 1'b1;
                            end else if (loop_r) begin
                                phase_inc   <= start_r;
                                step_strobe <= 1'b1;
                            end else begin
                                busy  <= 1'b0;
                                done  <= 1'b1;
                                state <= IDLE;
                            end
                        end else begin
                            dwell_cnt <= dwell_cnt - DW'(1);
                        end
                    end
                end

                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// -----------------------------------------------------------------------------
// tb_dds_sweep_ctrl
//
// Self-checking bench for dds_sweep_ctrl: a directed vector table for a single
// sweep, hand sequences for loop/abort/overflow/reset corners, and randomized
// sweeps compared every cycle against an arithmetic reference model.
// -----------------------------------------------------------------------------
module tb_dds_sweep_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        frame_tick;
    logic [31:0] cfg_start_inc;
    logic [31:0] cfg_stop_inc;
    logic [31:0] cfg_step;
    logic [15:0] cfg_dwell;
    logic        cfg_loop;
    logic        go;
    logic        abort;
    logic [31:0] phase_inc;
    logic        busy;
    logic        done;
    logic        step_strobe;

    int unsigned n_total = 0;
    int unsigned n_pass  = 0;

    dds_sweep_ctrl #(.PW(32), .DW(16), .RST_INC(32'd100000)) dut (
        .clk           (clk),
        .rst           (rst),
        .frame_tick    (frame_tick),
        .cfg_start_inc (cfg_start_inc),
        .cfg_stop_inc  (cfg_stop_inc),
        .cfg_step      (cfg_step),
        .cfg_dwell     (cfg_dwell),
        .cfg_loop      (cfg_loop),
        .go            (go),
        .abort         (abort),
        .phase_inc     (phase_inc),
        .busy          (busy),
        .done          (done),
        .step_strobe   (step_strobe)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    // The sweep is the arithmetic series start + k*step, k = 0..len-1, with
    // len = floor((stop-start)/step)+1 (len 1 if start>stop, unbounded if step=0).
    longint unsigned m_start, m_stop, m_step, m_len, m_pos;
    int unsigned     m_dwell, m_ticks;
    bit              m_loop, m_busy, m_done, m_str, m_inf;
    logic [31:0]     m_phase;

    function automatic void model_reset();
        m_busy = 0; m_done = 0; m_str = 0; m_phase = 32'd100000;
        m_pos = 0; m_ticks = 0; m_len = 1; m_inf = 0;
    endfunction

    function automatic void model_edge(bit g, bit a, bit t);
        m_done = 0;
        m_str  = 0;
        if (!m_busy) begin
            if (g && !a) begin
                m_start = longint'(cfg_start_inc);
                m_stop  = longint'(cfg_stop_inc);
                m_step  = longint'(cfg_step);
                m_loop  = cfg_loop;
                m_dwell = (cfg_dwell == 0) ? 1 : int'(cfg_dwell);
                m_inf   = 0;
                if (m_start > m_stop)  m_len = 1;
                else if (m_step == 0) begin m_len = 1; m_inf = 1; end
                else                   m_len = (m_stop - m_start) / m_step + 1;
                m_pos   = 0;
                m_ticks = 0;
                m_phase = cfg_start_inc;
                m_busy  = 1;
                m_str   = 1;
            end
        end else if (a) begin
            m_busy = 0;
        end else if (t) begin
            m_ticks++;
            if (m_ticks == m_dwell) begin
                m_ticks = 0;
                if (m_inf) begin
                    m_str = 1;
                end else if (m_pos + 1 < m_len) begin
                    m_pos++;
                    m_phase = 32'(m_start + m_pos * m_step);
                    m_str = 1;
                end else if (m_loop) begin
                    m_pos = 0;
                    m_phase = 32'(m_start);
                    m_str = 1;
                end else begin
                    m_busy = 0;
                    m_done = 1;
                end
            end
        end
    endfunction

    // ---------------- helpers ----------------
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", nm, act, exp, $time);
    endtask

    task automatic chk_model();
        chk("model phase_inc", phase_inc, m_phase);
        chk("model busy", {31'd0, busy}, {31'd0, m_busy});
        chk("model done", {31'd0, done}, {31'd0, m_done});
        chk("model step_strobe", {31'd0, step_strobe}, {31'd0, m_str});
    endtask

    task automatic chk_out(input string nm, input logic [31:0] ph, input bit b,
                           input bit d, input bit s);
        chk({nm, " phase_inc"}, phase_inc, ph);
        chk({nm, " busy"}, {31'd0, busy}, {31'd0, b});
        chk({nm, " done"}, {31'd0, done}, {31'd0, d});
        chk({nm, " step_strobe"}, {31'd0, step_strobe}, {31'd0, s});
    endtask

    // Apply inputs for one cycle, advance the model, sample 1 ns after the edge.
    task automatic cyc(input bit g, input bit a, input bit t);
        go = g; abort = a; frame_tick = t;
        model_edge(g, a, t);
        @(posedge clk);
        #1;
        chk_model();
        go = 0; abort = 0; frame_tick = 0;
    endtask

    task automatic set_cfg(input logic [31:0] s, input logic [31:0] e, input logic [31:0] st,
                           input logic [15:0] d, input bit l);
        cfg_start_inc = s; cfg_stop_inc = e; cfg_step = st; cfg_dwell = d; cfg_loop = l;
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        bit          go, abort, tick;
        logic [31:0] start, stop, step;
        logic [15:0] dwell;
        bit          lp;
        logic [31:0] e_phase;
        bit          e_busy, e_done, e_str;
    } vec_t;

    vec_t vecs[11];

    initial begin
        int unsigned strobes;
        logic [31:0] loop_exp[6];

        // Row 0 starts the sweep (same-cycle tick not counted); later rows carry
        // different cfg values and a re-pulsed go that the running sweep ignores.
        vecs[0]  = '{1,0,1, 1000,1300,100,2,0, 1000,1,0,1};
        vecs[1]  = '{0,0,1,    5,   9,  1,0,1, 1000,1,0,0};
        vecs[2]  = '{0,0,1,    5,   9,  1,0,1, 1100,1,0,1};
        vecs[3]  = '{1,0,0,    5,   9,  1,0,1, 1100,1,0,0};
        vecs[4]  = '{0,0,1,    5,   9,  1,0,1, 1100,1,0,0};
        vecs[5]  = '{1,0,1,    5,   9,  1,0,1, 1200,1,0,1};
        vecs[6]  = '{0,0,1,    5,   9,  1,0,1, 1200,1,0,0};
        vecs[7]  = '{0,0,1,    5,   9,  1,0,1, 1300,1,0,1};
        vecs[8]  = '{0,0,1,    5,   9,  1,0,1, 1300,1,0,0};
        vecs[9]  = '{0,0,1,    5,   9,  1,0,1, 1300,0,1,0};
        vecs[10] = '{0,0,0,    5,   9,  1,0,1, 1300,0,0,0};

        rst = 1; go = 0; abort = 0; frame_tick = 0;
        set_cfg(0, 0, 0, 0, 0);
        model_reset();
        #1;
        chk_out("reset", 32'd100000, 0, 0, 0);
        @(negedge clk); @(negedge clk);
        rst = 0;
        for (int i = 0; i < 3; i++) cyc(0, 0, 1);
        chk_out("idle after reset", 32'd100000, 0, 0, 0);

        // Single sweep from the table.
        strobes = 0;
        for (int i = 0; i < 11; i++) begin
            set_cfg(vecs[i].start, vecs[i].stop, vecs[i].step, vecs[i].dwell, vecs[i].lp);
            cyc(vecs[i].go, vecs[i].abort, vecs[i].tick);
            chk_out($sformatf("vec%0d", i), vecs[i].e_phase, vecs[i].e_busy,
                    vecs[i].e_done, vecs[i].e_str);
            if (step_strobe) strobes++;
        end
        chk("sweep strobe count", strobes, 4);

        // Loop mode: 10,20 repeated, never done.
        loop_exp = '{20, 10, 20, 10, 20, 10};
        set_cfg(10, 25, 10, 1, 1);
        cyc(1, 0, 0);
        chk_out("loop load", 10, 1, 0, 1);
        for (int i = 0; i < 6; i++) begin
            cyc(0, 0, 1);
            chk_out($sformatf("loop tick%0d", i), loop_exp[i], 1, 0, 1);
        end
        cyc(0, 1, 0);
        chk_out("loop abort", 10, 0, 0, 0);

        // Abort after one of three dwell ticks.
        set_cfg(500, 1000, 10, 3, 0);
        cyc(1, 0, 0);
        cyc(0, 0, 1);
        cyc(0, 1, 0);
        chk_out("abort mid dwell", 500, 0, 0, 0);
        // Abort coincident with the completing tick: no advance.
        cyc(1, 0, 0);
        cyc(0, 0, 1);
        cyc(0, 0, 1);
        cyc(0, 1, 1);
        chk_out("abort on advance", 500, 0, 0, 0);

        // Overflow: stops at 0xFFFFFF80 instead of wrapping.
        set_cfg(32'hFFFFFF00, 32'hFFFFFFFF, 32'h80, 1, 0);
        cyc(1, 0, 0);
        chk_out("ovf load", 32'hFFFFFF00, 1, 0, 1);
        cyc(0, 0, 1);
        chk_out("ovf step", 32'hFFFFFF80, 1, 0, 1);
        cyc(0, 0, 1);
        chk_out("ovf end", 32'hFFFFFF80, 0, 1, 0);

        // go and abort together in IDLE.
        set_cfg(7, 70, 7, 1, 0);
        cyc(1, 1, 0);
        chk_out("go+abort idle", 32'hFFFFFF80, 0, 0, 0);

        // dwell=0 acts as 1.
        set_cfg(3, 5, 1, 0, 0);
        cyc(1, 0, 0);
        cyc(0, 0, 1);
        chk_out("dwell0 a", 4, 1, 0, 1);
        cyc(0, 0, 1);
        chk_out("dwell0 b", 5, 1, 0, 1);
        cyc(0, 0, 1);
        chk_out("dwell0 end", 5, 0, 1, 0);

        // Asynchronous reset mid-sweep.
        set_cfg(2000, 9000, 50, 2, 1);
        cyc(1, 0, 0);
        cyc(0, 0, 1);
        #2 rst = 1;
        #1;
        chk_out("async reset", 32'd100000, 0, 0, 0);
        model_reset();
        @(negedge clk);
        rst = 0;
        cyc(0, 0, 1);
        chk_out("post reset idle", 32'd100000, 0, 0, 0);

        // Randomized sweeps against the model.
        for (int s = 0; s < 25; s++) begin
            longint unsigned st, sp;
            st = longint'($urandom);
            if ($urandom_range(0, 3) == 0) st = 64'hFFFFFFFF - longint'($urandom_range(0, 2000));
            sp = st + longint'($urandom_range(0, 3000));
            if (sp > 64'hFFFFFFFF) sp = 64'hFFFFFFFF;
            if ($urandom_range(0, 7) == 0) sp = (st > 100) ? st - 100 : st;
            set_cfg(32'(st), 32'(sp),
                    ($urandom_range(0, 5) == 0) ? 32'd0 : 32'($urandom_range(1, 900)),
                    16'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
            if (busy) cyc(0, 1, 0);
            cyc(1, 0, $urandom_range(0, 1) == 1);
            for (int c = 0; c < 60; c++) begin
                if ($urandom_range(0, 9) == 0) begin
                    cfg_start_inc = $urandom; cfg_step = $urandom;
                    cfg_stop_inc = $urandom; cfg_dwell = 16'($urandom);
                end
                cyc($urandom_range(0, 19) == 0, $urandom_range(0, 59) == 0,
                    $urandom_range(0, 1) == 1);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
